xfer_ctrl: RTL and testbench
============================

Name: xfer_ctrl

Overview:
Command-driven sequencer for the shared 16x4 register file and 16x4 RAM datapath. It accepts one transfer command at a time over a valid/ready handshake. It drives the register-file and RAM control, address and data pins through a fixed multi-cycle schedule, and returns one response pulse per command. It replaces ad-hoc combinational steering of both storage blocks, including the whole-array clear.

Parameters:
DW, 4, data word width of register file and RAM
AW, 4, address width; both arrays hold 2^AW words

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  3  operation code (see Behaviour)
cmd_raddr  in  AW  register-file address
cmd_maddr  in  AW  RAM address
cmd_data  in  DW  write data for RF_WR/RAM_WR
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  DW  response data, valid with rsp_valid
busy  out  1  high whenever not IDLE
rf_we  out  1  register-file write strobe
rf_addr  out  AW  register-file address
rf_wdata  out  DW  register-file write data
rf_rdata  in  DW  register-file read data, valid 1 cycle after rf_addr presented
ram_we  out  1  RAM write strobe
ram_rd  out  1  RAM read strobe
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, valid 1 cycle after ram_rd

Behaviour:
- Opcodes:
  - 000 RF_RD, 001 RAM_RD, 010 RF_WR, 011 RAM_WR.
  - 100 RAM2RF: RAM[maddr] -> RF[raddr].
  - 101 RF2RAM: RF[raddr] -> RAM[maddr].
  - 110 CLR_RF, 111 CLR_RAM.
- Reset (asynchronous, immediate):
  - state=IDLE; all strobes, rsp_valid, busy and addresses are 0; wdata outputs and rsp_data are 0; clear counter is 0.
  - Cmd regs are 0.
- cmd_ready = (state==IDLE). A command is accepted on a cycle with cmd_valid && cmd_ready. Op, addresses and data are latched at acceptance; later input changes are ignored.
- FSM states: IDLE, RD, CAP, WR, CLR, RSP.
- IDLE on accept:
  - RF_WR/RAM_WR -> WR.
  - RF_RD/RAM_RD/moves -> RD.
  - clears -> CLR with cnt=0.
- RD: rf_addr=raddr for RF-sourced ops. For RAM-sourced ops, ram_addr=maddr and ram_rd=1 for this cycle only. Next state is CAP.
- CAP: the source rdata is captured into an internal data register. Reads go to RSP; moves go to WR.
- WR: one-cycle we on the destination with latched address. Write data is cmd_data for writes and the captured data for moves. Next state is RSP.
- CLR: we=1 on the target array, wdata=0, addr=cnt. cnt increments each cycle. After the cycle with cnt==2^AW-1, go to RSP. cnt wraps to 0.
- RSP: rsp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- rsp_data:
  - reads and moves: the value read.
  - writes: the value written.
  - clears: 0.
- Latency, with acceptance in cycle T:
  - writes: we at T+1, rsp at T+2.
  - reads: rd at T+1, rsp at T+3.
  - moves: rd T+1, we T+3, rsp T+4.
  - clears: we at T+1..T+2^AW, rsp at T+2^AW+1.
- Next command acceptance is possible in the cycle after RSP. Back-to-back throughput is 1 command per (latency+1) cycles.
- Strobe rules:
  - rf_we and ram_we are never high in the same cycle; ram_rd and ram_we are never high together.
  - Addresses not in use hold their last driven value.
- cmd_valid while busy: ignored. The requester must hold the command until cmd_ready.
- rst asserted mid-operation: the operation aborts at once, strobes drop asynchronously, no rsp_valid is issued, and partial clears are left as-is.

Test Plan:
- Reset: rst=1 mid-clock -> all outputs 0 immediately, cmd_ready=1 after release.
- RF_WR raddr=5 data=1111, then RF_RD raddr=5 -> rf_we pulse at T+1 with addr 5/data 1111, rsp_data=1111 at T+2. The read returns 1111 at T+3.
- RAM_WR maddr=A data=1010, then RAM2RF maddr=A raddr=1, then RF_RD raddr=1 -> rsp 1010 each; ram_rd exactly one cycle; rf_we at T+3.
- RF2RAM raddr=5 maddr=1 after RF[5]=1111 -> ram_we at T+3 addr 1 data 1111; RAM_RD maddr=1 returns 1111.
- CLR_RAM -> ram_we high 16 consecutive cycles, addr 0..F, wdata 0, rsp at T+17 with data 0; cmd_valid held during clear is not accepted until IDLE.
- Abort: assert rst during CLR at cnt=7 -> ram_we falls immediately, no rsp_valid; a subsequent RAM_RD 3 returns 0 and RAM_RD 9 returns the pre-clear value.

Source files
------------

// File: rtl/xfer_ctrl.sv
// rtl/xfer_ctrl.sv - command sequencer for the shared register file and RAM
//
// Accepts one command at a time (cmd_valid/cmd_ready), steps the register
// file and RAM pins through a fixed schedule and emits one rsp_valid pulse
// per command.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                000 RF_RD, 001 RAM_RD, 010 RF_WR, 011 RAM_WR,
//                         100 RAM2RF, 101 RF2RAM, 110 CLR_RF, 111 CLR_RAM
//   cmd_raddr/cmd_maddr   register-file / RAM address
//   cmd_data              write data for RF_WR / RAM_WR
//   rsp_valid/rsp_data    one-cycle response pulse and its data
//   busy                  high whenever not IDLE
//   rf_we/rf_addr/rf_wdata/rf_rdata          register-file pins
//   ram_we/ram_rd/ram_addr/ram_wdata/ram_rdata RAM pins
module xfer_ctrl #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_raddr,
  input  logic [AW-1:0] cmd_maddr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_rdata,
  output logic          ram_we,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [2:0] OP_RF_RD   = 3'b000;
  localparam logic [2:0] OP_RAM_RD  = 3'b001;
  localparam logic [2:0] OP_RF_WR   = 3'b010;
  localparam logic [2:0] OP_RAM_WR  = 3'b011;
  localparam logic [2:0] OP_RAM2RF  = 3'b100;
  localparam logic [2:0] OP_RF2RAM  = 3'b101;
  localparam logic [2:0] OP_CLR_RF  = 3'b110;
  localparam logic [2:0] OP_CLR_RAM = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_WR, S_CLR, S_RSP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] cdata_q, cdata_d;        // cmd_data latched at acceptance
  logic [DW-1:0] data_q, data_d;          // value captured from the source array
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rf_addr_q, rf_addr_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic          src_ram, dst_rf, is_move;
  logic          acc_rf, acc_ram, acc_clr;
  logic [DW-1:0] src_rdata;
  logic [AW-1:0] cnt_inc;

  // Operation decode: latched op for the running command, cmd_op at acceptance.
  always_comb begin
    src_ram   = (op_q == OP_RAM_RD) || (op_q == OP_RAM2RF);
    dst_rf    = (op_q == OP_RF_WR) || (op_q == OP_RAM2RF) || (op_q == OP_CLR_RF);
    is_move   = (op_q == OP_RAM2RF) || (op_q == OP_RF2RAM);
    src_rdata = src_ram ? ram_rdata : rf_rdata;
    cnt_inc   = cnt_q + 1'b1;
    acc_clr   = (cmd_op == OP_CLR_RF) || (cmd_op == OP_CLR_RAM);
    acc_rf    = (cmd_op == OP_RF_RD) || (cmd_op == OP_RF_WR) || (cmd_op == OP_RAM2RF) ||
                (cmd_op == OP_RF2RAM) || (cmd_op == OP_CLR_RF);
    acc_ram   = (cmd_op == OP_RAM_RD) || (cmd_op == OP_RAM_WR) || (cmd_op == OP_RAM2RF) ||
                (cmd_op == OP_RF2RAM) || (cmd_op == OP_CLR_RAM);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cdata_d     = cdata_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rf_addr_d   = rf_addr_q;
    ram_addr_d  = ram_addr_q;
    rf_wdata_d  = rf_wdata_q;
    ram_wdata_d = ram_wdata_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          cdata_d = cmd_data;
          // Address registers are loaded only for the arrays this command
          // touches, so an untouched array keeps its last address.
          if (acc_rf)  rf_addr_d  = acc_clr ? '0 : cmd_raddr;
          if (acc_ram) ram_addr_d = acc_clr ? '0 : cmd_maddr;
          case (cmd_op)
            OP_RF_WR: begin
              rf_wdata_d = cmd_data;
              state_d    = S_WR;
            end
            OP_RAM_WR: begin
              ram_wdata_d = cmd_data;
              state_d     = S_WR;
            end
            OP_CLR_RF: begin
              rf_wdata_d = '0;
              cnt_d      = '0;
              state_d    = S_CLR;
            end
            OP_CLR_RAM: begin
              ram_wdata_d = '0;
              cnt_d       = '0;
              state_d     = S_CLR;
            end
            default: state_d = S_RD;
          endcase
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        data_d = src_rdata;
        if (is_move) begin
          if (dst_rf) rf_wdata_d  = src_rdata;
          else        ram_wdata_d = src_rdata;
          state_d = S_WR;
        end else begin
          rsp_data_d = src_rdata;
          state_d    = S_RSP;
        end
      end
      S_WR: begin
        rsp_data_d = is_move ? data_q : cdata_q;
        state_d    = S_RSP;
      end
      S_CLR: begin
        cnt_d = cnt_inc;
        if (cnt_q == '1) begin
          rsp_data_d = '0;
          state_d    = S_RSP;
        end else if (dst_rf) begin
          rf_addr_d = cnt_inc;
        end else begin
          ram_addr_d = cnt_inc;
        end
      end
      S_RSP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cdata_q     <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      rf_addr_q   <= '0;
      ram_addr_q  <= '0;
      rf_wdata_q  <= '0;
      ram_wdata_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cdata_q     <= cdata_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      rf_addr_q   <= rf_addr_d;
      ram_addr_q  <= ram_addr_d;
      rf_wdata_q  <= rf_wdata_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset removes them immediately. WR/CLR target exactly one array and
  // RD never writes, which keeps the strobes mutually exclusive.
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rf_we     = ((state_q == S_WR) || (state_q == S_CLR)) && dst_rf;
  assign ram_we    = ((state_q == S_WR) || (state_q == S_CLR)) && !dst_rf;
  assign ram_rd    = (state_q == S_RD) && src_ram;
  assign rf_addr   = rf_addr_q;
  assign ram_addr  = ram_addr_q;
  assign rf_wdata  = rf_wdata_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_xfer_ctrl.sv
// tb/tb_xfer_ctrl.sv - directed self-checking bench for xfer_ctrl
module tb_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [3:0] cmd_raddr = 4'h0;
  logic [3:0] cmd_maddr = 4'h0;
  logic [3:0] cmd_data = 4'h0;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       busy;
  logic       rf_we;
  logic [3:0] rf_addr;
  logic [3:0] rf_wdata;
  logic [3:0] rf_rdata = 4'h0;
  logic       ram_we;
  logic       ram_rd;
  logic [3:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata = 4'h0;

  int compared = 0;
  int mismatched = 0;

  // Storage models; RAM starts with RAM[i] = 15 - i, RF with RF[i] = i.
  logic [3:0] rf_mem [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                              4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  logic [3:0] ram_mem [16] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
                               4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};

  // Per-cycle trace of one command; index k is cycle T+k after acceptance.
  logic [19:0] t_rf_we, t_ram_we, t_ram_rd, t_rsp_valid, t_busy, t_cmd_ready;
  logic [3:0]  t_rf_addr [20];
  logic [3:0]  t_ram_addr [20];
  logic [3:0]  t_rf_wdata [20];
  logic [3:0]  t_ram_wdata [20];
  logic [3:0]  t_rsp_data [20];

  xfer_ctrl #(.DW(4), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_raddr(cmd_raddr), .cmd_maddr(cmd_maddr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .ram_we(ram_we), .ram_rd(ram_rd), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we)  rf_mem[rf_addr]   <= rf_wdata;
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    rf_rdata <= rf_mem[rf_addr];
    if (ram_rd) ram_rdata <= ram_mem[ram_addr];
  end

  // Issue one command and trace n cycles after acceptance. With hold set,
  // cmd_valid stays high afterwards carrying RF_WR raddr=2 data=3.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] ma,
                         input logic [3:0] d, input int n, input bit hold, output int waited);
    t_rf_we = '0; t_ram_we = '0; t_ram_rd = '0; t_rsp_valid = '0; t_busy = '0; t_cmd_ready = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_raddr = ra; cmd_maddr = ma; cmd_data = d;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL accept_timeout op=%b: cmd_ready=%b required 1", op, cmd_ready);
    end
    @(negedge clk);
    if (hold) begin
      cmd_op = 3'b010; cmd_raddr = 4'h2; cmd_maddr = 4'h0; cmd_data = 4'h3;
    end else begin
      cmd_valid = 1'b0; cmd_op = ~op; cmd_raddr = ~ra; cmd_maddr = ~ma; cmd_data = ~d;
    end
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge clk);
      t_rf_we[k] = rf_we; t_ram_we[k] = ram_we; t_ram_rd[k] = ram_rd;
      t_rsp_valid[k] = rsp_valid; t_busy[k] = busy; t_cmd_ready[k] = cmd_ready;
      t_rf_addr[k] = rf_addr; t_ram_addr[k] = ram_addr;
      t_rf_wdata[k] = rf_wdata; t_ram_wdata[k] = ram_wdata; t_rsp_data[k] = rsp_data;
      compared++;
      if ((rf_we && ram_we) || (ram_rd && ram_we)) begin
        mismatched++;
        $display("FAIL strobe_overlap op=%b k=%0d: rf_we=%b ram_we=%b ram_rd=%b required no overlap",
                 op, k, rf_we, ram_we, ram_rd);
      end
    end
  endtask

  task automatic test_reset();
    int w;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, rf_we, ram_we, ram_rd, rsp_valid} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_strobes: got %b required 00000", {busy, rf_we, ram_we, ram_rd, rsp_valid});
    end
    compared++;
    if ({rf_addr, ram_addr, rf_wdata, ram_wdata, rsp_data} !== 20'h0) begin
      mismatched++;
      $display("FAIL reset_regs: got %h required 00000", {rf_addr, ram_addr, rf_wdata, ram_wdata, rsp_data});
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
    // Abort an RF_WR in its write cycle; the write must never land.
    run_cmd(3'b010, 4'h6, 4'h0, 4'hC, 1, 1'b0, w);
    compared++;
    if (rf_we !== 1'b1 || rf_addr !== 4'h6) begin
      mismatched++;
      $display("FAIL abort_pre_we: rf_we=%b addr=%h required 1/6", rf_we, rf_addr);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({rf_we, busy, rsp_valid, rf_addr, rf_wdata} !== 11'h0) begin
      mismatched++;
      $display("FAIL abort_async: got %h required 000", {rf_we, busy, rsp_valid, rf_addr, rf_wdata});
    end
    @(negedge clk);
    rst = 1'b0;
    run_cmd(3'b000, 4'h6, 4'h0, 4'h0, 3, 1'b0, w);
    compared++;
    if (t_rsp_valid !== 20'h00008 || t_rsp_data[3] !== 4'h6) begin
      mismatched++;
      $display("FAIL abort_rf6_kept: rsp=%h data=%h required 00008/6", t_rsp_valid, t_rsp_data[3]);
    end
  endtask

  task automatic test_rf_wr_rd();
    int w;
    run_cmd(3'b010, 4'h5, 4'h0, 4'hF, 2, 1'b0, w);
    compared++;
    if (t_rf_we !== 20'h00002 || t_ram_we !== 20'h0 || t_ram_rd !== 20'h0) begin
      mismatched++;
      $display("FAIL rfwr_strobes: rf_we=%h ram_we=%h ram_rd=%h required 00002/0/0", t_rf_we, t_ram_we, t_ram_rd);
    end
    compared++;
    if (t_rf_addr[1] !== 4'h5 || t_rf_wdata[1] !== 4'hF) begin
      mismatched++;
      $display("FAIL rfwr_addr_data: addr=%h data=%h required 5/f", t_rf_addr[1], t_rf_wdata[1]);
    end
    compared++;
    if (t_rsp_valid !== 20'h00004 || t_rsp_data[2] !== 4'hF || t_busy !== 20'h00006) begin
      mismatched++;
      $display("FAIL rfwr_rsp: rsp=%h data=%h busy=%h required 00004/f/00006", t_rsp_valid, t_rsp_data[2], t_busy);
    end
    run_cmd(3'b000, 4'h5, 4'h0, 4'h0, 3, 1'b0, w);
    compared++;
    if (t_rsp_valid !== 20'h00008 || t_rsp_data[3] !== 4'hF || t_rf_we !== 20'h0) begin
      mismatched++;
      $display("FAIL rfrd_rsp: rsp=%h data=%h rf_we=%h required 00008/f/0", t_rsp_valid, t_rsp_data[3], t_rf_we);
    end
  endtask

  task automatic test_ram2rf();
    int w;
    run_cmd(3'b011, 4'h0, 4'hA, 4'hA, 2, 1'b0, w);
    compared++;
    if (t_ram_we !== 20'h00002 || t_ram_addr[1] !== 4'hA || t_ram_wdata[1] !== 4'hA ||
        t_rsp_valid !== 20'h00004 || t_rsp_data[2] !== 4'hA) begin
      mismatched++;
      $display("FAIL ramwr: we=%h addr=%h wd=%h rsp=%h data=%h required 00002/a/a/00004/a",
               t_ram_we, t_ram_addr[1], t_ram_wdata[1], t_rsp_valid, t_rsp_data[2]);
    end
    run_cmd(3'b100, 4'h1, 4'hA, 4'h0, 4, 1'b0, w);
    compared++;
    if (t_ram_rd !== 20'h00002 || t_ram_addr[1] !== 4'hA) begin
      mismatched++;
      $display("FAIL ram2rf_rd: ram_rd=%h addr=%h required 00002/a", t_ram_rd, t_ram_addr[1]);
    end
    compared++;
    if (t_rf_we !== 20'h00008 || t_rf_addr[3] !== 4'h1 || t_rf_wdata[3] !== 4'hA || t_ram_we !== 20'h0) begin
      mismatched++;
      $display("FAIL ram2rf_we: rf_we=%h addr=%h wd=%h ram_we=%h required 00008/1/a/0",
               t_rf_we, t_rf_addr[3], t_rf_wdata[3], t_ram_we);
    end
    compared++;
    if (t_rsp_valid !== 20'h00010 || t_rsp_data[4] !== 4'hA) begin
      mismatched++;
      $display("FAIL ram2rf_rsp: rsp=%h data=%h required 00010/a", t_rsp_valid, t_rsp_data[4]);
    end
    run_cmd(3'b000, 4'h1, 4'h0, 4'h0, 3, 1'b0, w);
    compared++;
    if (t_rsp_valid !== 20'h00008 || t_rsp_data[3] !== 4'hA) begin
      mismatched++;
      $display("FAIL rf1_readback: rsp=%h data=%h required 00008/a", t_rsp_valid, t_rsp_data[3]);
    end
  endtask

  task automatic test_rf2ram();
    int w;
    run_cmd(3'b101, 4'h5, 4'h1, 4'h0, 4, 1'b0, w);
    compared++;
    if (t_ram_we !== 20'h00008 || t_ram_addr[3] !== 4'h1 || t_ram_wdata[3] !== 4'hF ||
        t_rf_we !== 20'h0 || t_ram_rd !== 20'h0) begin
      mismatched++;
      $display("FAIL rf2ram_we: ram_we=%h addr=%h wd=%h rf_we=%h ram_rd=%h required 00008/1/f/0/0",
               t_ram_we, t_ram_addr[3], t_ram_wdata[3], t_rf_we, t_ram_rd);
    end
    compared++;
    if (t_rf_addr[1] !== 4'h5 || t_rsp_valid !== 20'h00010 || t_rsp_data[4] !== 4'hF) begin
      mismatched++;
      $display("FAIL rf2ram_rsp: rf_addr=%h rsp=%h data=%h required 5/00010/f",
               t_rf_addr[1], t_rsp_valid, t_rsp_data[4]);
    end
    run_cmd(3'b001, 4'h0, 4'h1, 4'h0, 3, 1'b0, w);
    compared++;
    if (t_ram_rd !== 20'h00002 || t_rsp_valid !== 20'h00008 || t_rsp_data[3] !== 4'hF) begin
      mismatched++;
      $display("FAIL ram1_readback: ram_rd=%h rsp=%h data=%h required 00002/00008/f",
               t_ram_rd, t_rsp_valid, t_rsp_data[3]);
    end
  endtask

  task automatic test_clear_abort();
    int w;
    logic seen_rsp;
    run_cmd(3'b111, 4'h0, 4'h0, 4'h0, 8, 1'b0, w);
    compared++;
    if (ram_we !== 1'b1 || ram_addr !== 4'h7 || t_ram_we !== 20'h001FE) begin
      mismatched++;
      $display("FAIL clrab_pre: ram_we=%b addr=%h trace=%h required 1/7/001fe", ram_we, ram_addr, t_ram_we);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({ram_we, busy, rsp_valid, ram_addr} !== 7'h0) begin
      mismatched++;
      $display("FAIL clrab_async: got %h required 00", {ram_we, busy, rsp_valid, ram_addr});
    end
    @(negedge clk);
    rst = 1'b0;
    seen_rsp = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1'b1;
    end
    compared++;
    if (seen_rsp !== 1'b0) begin
      mismatched++;
      $display("FAIL clrab_no_rsp: rsp_valid seen=%b required 0", seen_rsp);
    end
    run_cmd(3'b001, 4'h0, 4'h3, 4'h0, 3, 1'b0, w);
    compared++;
    if (t_rsp_data[3] !== 4'h0) begin
      mismatched++;
      $display("FAIL clrab_ram3: got %h required 0", t_rsp_data[3]);
    end
    run_cmd(3'b001, 4'h0, 4'h7, 4'h0, 3, 1'b0, w);
    compared++;
    if (t_rsp_data[3] !== 4'h8) begin
      mismatched++;
      $display("FAIL clrab_ram7: got %h required 8", t_rsp_data[3]);
    end
    run_cmd(3'b001, 4'h0, 4'h9, 4'h0, 3, 1'b0, w);
    compared++;
    if (t_rsp_data[3] !== 4'h6) begin
      mismatched++;
      $display("FAIL clrab_ram9: got %h required 6", t_rsp_data[3]);
    end
  endtask

  task automatic test_clear_full();
    int w;
    run_cmd(3'b111, 4'h0, 4'h0, 4'h0, 17, 1'b1, w);
    compared++;
    if (t_ram_we !== 20'h1FFFE || t_rf_we !== 20'h0) begin
      mismatched++;
      $display("FAIL clr_we: ram_we=%h rf_we=%h required 1fffe/0", t_ram_we, t_rf_we);
    end
    for (int k = 1; k <= 16; k++) begin
      compared++;
      if (t_ram_addr[k] !== 4'(k - 1) || t_ram_wdata[k] !== 4'h0) begin
        mismatched++;
        $display("FAIL clr_addr k=%0d: addr=%h wd=%h required %h/0", k, t_ram_addr[k], t_ram_wdata[k], 4'(k - 1));
      end
    end
    compared++;
    if (t_rsp_valid !== 20'h20000 || t_rsp_data[17] !== 4'h0 || t_cmd_ready !== 20'h0) begin
      mismatched++;
      $display("FAIL clr_rsp: rsp=%h data=%h ready=%h required 20000/0/0", t_rsp_valid, t_rsp_data[17], t_cmd_ready);
    end
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1 || rf_we !== 1'b0) begin
      mismatched++;
      $display("FAIL clr_held_ready: ready=%b rf_we=%b required 1/0", cmd_ready, rf_we);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    compared++;
    if (rf_we !== 1'b1 || rf_addr !== 4'h2 || rf_wdata !== 4'h3) begin
      mismatched++;
      $display("FAIL clr_held_accept: rf_we=%b addr=%h wd=%h required 1/2/3", rf_we, rf_addr, rf_wdata);
    end
    @(negedge clk);
    run_cmd(3'b001, 4'h0, 4'hA, 4'h0, 3, 1'b0, w);
    compared++;
    if (t_rsp_data[3] !== 4'h0) begin
      mismatched++;
      $display("FAIL clr_ramA: got %h required 0", t_rsp_data[3]);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    run_cmd(3'b010, 4'h3, 4'h0, 4'h9, 2, 1'b0, w);
    run_cmd(3'b000, 4'h3, 4'h0, 4'h0, 3, 1'b0, w);
    compared++;
    if (w !== 0 || t_rsp_data[3] !== 4'h9 || t_rsp_valid !== 20'h00008) begin
      mismatched++;
      $display("FAIL b2b: wait=%0d data=%h rsp=%h required 0/9/00008", w, t_rsp_data[3], t_rsp_valid);
    end
    run_cmd(3'b110, 4'h0, 4'h0, 4'h0, 17, 1'b0, w);
    compared++;
    if (w !== 0 || t_rf_we !== 20'h1FFFE || t_rf_addr[16] !== 4'hF || t_rsp_valid !== 20'h20000) begin
      mismatched++;
      $display("FAIL b2b_clr_rf: wait=%0d we=%h addr=%h rsp=%h required 0/1fffe/f/20000",
               w, t_rf_we, t_rf_addr[16], t_rsp_valid);
    end
    run_cmd(3'b000, 4'h3, 4'h0, 4'h0, 3, 1'b0, w);
    compared++;
    if (w !== 0 || t_rsp_data[3] !== 4'h0) begin
      mismatched++;
      $display("FAIL b2b_rf3_cleared: wait=%0d data=%h required 0/0", w, t_rsp_data[3]);
    end
  endtask

  initial begin
    test_reset();
    test_rf_wr_rd();
    test_ram2rf();
    test_rf2ram();
    test_clear_abort();
    test_clear_full();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
